// File: rtl/div_seq_unit.sv
// div_seq_unit: multicycle signed integer divider (DIV instruction).
// Restoring radix-2 division on operand magnitudes, one quotient bit per
// clock, followed by a single sign-correction cycle.
//
// Ports:
//   Clk            system clock, rising edge
//   Reset          asynchronous active-low reset
//   DivStart       start request, sampled only in IDLE
//   Dividendo      dividend (two's complement)
//   Divisor        divisor (two's complement)
//   Hi             remainder of the last completed division
//   Lo             quotient of the last completed division
//   DivFim         one-cycle completion strobe
//   DivisaoPorZero divisor was zero for the last accepted request
//   Busy           high while iterating or sign-fixing
//
// state  | meaning
// IDLE   | waiting for DivStart
// RUN    | one restoring iteration per clock, WIDTH iterations
// FIX    | apply signs, load Hi/Lo
// DONE   | DivFim high for one cycle

module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] Dividendo,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivFim,
    output logic             DivisaoPorZero,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;

    logic             last_iter;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_trial;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_it;
    logic [WIDTH-1:0] quo_it;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign abs_a     = Dividendo[WIDTH-1] ? (WIDTH'(0) - Dividendo) : Dividendo;
    assign abs_b     = Divisor[WIDTH-1]   ? (WIDTH'(0) - Divisor)   : Divisor;

    // The stored remainder is always below the divisor, so only the shifted
    // value needs the extra bit; the subtraction result fits in WIDTH bits
    // whenever it is actually taken.
    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        rem_ge    = (rem_sh >= {1'b0, dvs});
        rem_trial = rem_sh[WIDTH-1:0] - dvs;
        rem_it    = rem_ge ? rem_trial : rem_sh[WIDTH-1:0];
        quo_it    = {quo[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (DivStart) begin
                    state_nxt = (Divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            Hi             <= '0;
            Lo             <= '0;
            DivFim         <= 1'b0;
            DivisaoPorZero <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            state  <= state_nxt;
            Busy   <= (state_nxt == S_RUN) || (state_nxt == S_FIX);
            DivFim <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (DivStart) begin
                        if (Divisor == '0) begin
                            DivisaoPorZero <= 1'b1;
                        end else begin
                            DivisaoPorZero <= 1'b0;
                            quo            <= abs_a;
                            dvs            <= abs_b;
                            sign_q         <= Dividendo[WIDTH-1] ^ Divisor[WIDTH-1];
                            sign_r         <= Dividendo[WIDTH-1];
                            rem            <= '0;
                            cnt            <= '0;
                        end
                    end
                end
                S_RUN: begin
                    rem <= rem_it;
                    quo <= quo_it;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    Lo <= sign_q ? (WIDTH'(0) - quo) : quo;
                    Hi <= sign_r ? (WIDTH'(0) - rem) : rem;
                end
                default: ;
            endcase
        end
    end

endmodule
